spi_tx_sequencer: RTL and testbench

SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

---
 rtl/spi_tx_sequencer_if.sv | 37 +++
 rtl/spi_tx_sequencer.sv | 156 +++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_sequencer_if.sv
// Handshake and serial-control bundle between a word requester and spi_tx_sequencer.
// The miso/rx_data pair exists only when SPI_SEQ_RX_EN is defined.
interface spi_tx_sequencer_if;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        abort;
    logic [15:0] pts_data;
    logic        pts_en;
    logic [3:0]  pts_index;
    logic        sclk;
    logic        cs_n;
    logic        busy;
    logic        done;
`ifdef SPI_SEQ_RX_EN
    logic        miso;
    logic [15:0] rx_data;

    modport master (
        output tx_valid, tx_data, abort, miso,
        input  tx_ready, pts_data, pts_en, pts_index, sclk, cs_n, busy, done, rx_data
    );
    modport slave (
        input  tx_valid, tx_data, abort, miso,
        output tx_ready, pts_data, pts_en, pts_index, sclk, cs_n, busy, done, rx_data
    );
`else
    modport master (
        output tx_valid, tx_data, abort,
        input  tx_ready, pts_data, pts_en, pts_index, sclk, cs_n, busy, done
    );
    modport slave (
        input  tx_valid, tx_data, abort,
        output tx_ready, pts_data, pts_en, pts_index, sclk, cs_n, busy, done
    );
`endif
endinterface

// File: rtl/spi_tx_sequencer.sv
// SPI mode-0 frame sequencer driving an external parallel-to-serial stage, 16-bit MSB first.
// Optional receive path (miso -> rx_data) is enabled by defining SPI_SEQ_RX_EN.
//
// state | meaning
// IDLE  | ready for a word, cs_n high, sclk low
// SETUP | cs_n low, sclk low for CLK_DIV cycles before the first edge
// SHIFT | sclk toggles every CLK_DIV cycles, 16 rising + 16 falling
// HOLD  | sclk low, cs_n still low for CLK_DIV cycles, then done pulse
module spi_tx_sequencer #(
    parameter int unsigned CLK_DIV = 4
) (
    input logic          FPGA_clk,
    input logic          FPGA_rst_n,
    spi_tx_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        pts_en_q, pts_en_d;
    logic        done_q, done_d;
    logic [15:0] pts_data_q, pts_data_d;
    logic [3:0]  pts_index_q, pts_index_d;
`ifdef SPI_SEQ_RX_EN
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] rx_data_q, rx_data_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        pts_en_d    = pts_en_q;
        done_d      = 1'b0;
        pts_data_d  = pts_data_q;
        pts_index_d = pts_index_q;
`ifdef SPI_SEQ_RX_EN
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
`endif
        if (state_q != IDLE && bus.abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sclk_d   = 1'b0;
            cs_n_d   = 1'b1;
            busy_d   = 1'b0;
            pts_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        state_d     = SETUP;
                        cnt_d       = CNT_LOAD;
                        pts_data_d  = bus.tx_data;
                        pts_index_d = 4'd15;
                        pts_en_d    = 1'b1;
                        cs_n_d      = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == 8'd0) begin
                        state_d = SHIFT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 8'd0) begin
                        cnt_d  = CNT_LOAD;
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
`ifdef SPI_SEQ_RX_EN
                            rx_shift_d = {rx_shift_q[14:0], bus.miso};
`endif
                        end else if (pts_index_q == 4'd0) begin
                            // index 0 already on the wire: this fall closes the frame
                            state_d = HOLD;
                        end else begin
                            pts_index_d = pts_index_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_d  = IDLE;
                        cs_n_d   = 1'b1;
                        pts_en_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
`ifdef SPI_SEQ_RX_EN
                        rx_data_d = rx_shift_q;
`endif
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            pts_en_q    <= 1'b0;
            done_q      <= 1'b0;
            pts_data_q  <= '0;
            pts_index_q <= '0;
`ifdef SPI_SEQ_RX_EN
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            pts_en_q    <= pts_en_d;
            done_q      <= done_d;
            pts_data_q  <= pts_data_d;
            pts_index_q <= pts_index_d;
`ifdef SPI_SEQ_RX_EN
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
`endif
        end
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.busy      = busy_q;
    assign bus.pts_en    = pts_en_q;
    assign bus.done      = done_q;
    assign bus.pts_data  = pts_data_q;
    assign bus.pts_index = pts_index_q;
`ifdef SPI_SEQ_RX_EN
    assign bus.rx_data   = rx_data_q;
`endif
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Scoreboard bench for spi_tx_sequencer: three instances with CLK_DIV = 1, 2 and 4.
// Receive-path checks are compiled in when SPI_SEQ_RX_EN is defined.
module tb_spi_tx_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        tx_valid_a [3];
    logic [15:0] tx_data_a  [3];
    logic        abort_a    [3];
    logic [2:0]  ready_a, sclk_a, cs_n_a, busy_a, pts_en_a, done_a;
    logic [15:0] pts_data_a [3];
    logic [3:0]  idx_a      [3];
`ifdef SPI_SEQ_RX_EN
    logic [15:0] rx_data_a  [3];
    logic [15:0] rx_pat;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DIV = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        spi_tx_sequencer_if bus ();
        spi_tx_sequencer #(.CLK_DIV(DIV)) u_dut (
            .FPGA_clk  (clk),
            .FPGA_rst_n(rst_n),
            .bus       (bus)
        );
        assign bus.tx_valid = tx_valid_a[g];
        assign bus.tx_data  = tx_data_a[g];
        assign bus.abort    = abort_a[g];
        assign ready_a[g]   = bus.tx_ready;
        assign sclk_a[g]    = bus.sclk;
        assign cs_n_a[g]    = bus.cs_n;
        assign busy_a[g]    = bus.busy;
        assign pts_en_a[g]  = bus.pts_en;
        assign done_a[g]    = bus.done;
        assign pts_data_a[g] = bus.pts_data;
        assign idx_a[g]     = bus.pts_index;
`ifdef SPI_SEQ_RX_EN
        // slave device answers with the pattern bit matching the bit being sent
        assign bus.miso     = rx_pat[bus.pts_index];
        assign rx_data_a[g] = bus.rx_data;
`endif
    end

    typedef struct {
        logic [15:0] data;
        int          acc;
        logic [15:0] rx;
        bit          rx_chk;
    } sb_t;

    sb_t sbq [3][$];

    function automatic int div_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every done pulse and tracks the sclk/index sequence.
    logic [2:0] prev_sclk;
    logic [3:0] prev_idx [3];
    int         rises [3];
    int         falls [3];
    sb_t        mon_e;

    initial begin
        prev_sclk = '0;
        for (int k = 0; k < 3; k++) begin
            prev_idx[k] = '0;
            rises[k] = 0;
            falls[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && done_a[k]) begin
                if (sbq[k].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: inst %0d got done=1, expected no done (t=%0t)", k, $time);
                end else begin
                    mon_e = sbq[k].pop_front();
                    chk("done_latency", 32'(cyc - mon_e.acc), 32'(34 * div_of(k)));
                    chk("done_pts_data", {16'h0, pts_data_a[k]}, {16'h0, mon_e.data});
                    chk("frame_rises", 32'(rises[k]), 32'd16);
                    chk("frame_falls", 32'(falls[k]), 32'd16);
                    chk("done_cs_n", {31'h0, cs_n_a[k]}, 32'd1);
                    chk("done_busy", {31'h0, busy_a[k]}, 32'd0);
                    chk("done_index", {28'h0, idx_a[k]}, 32'd0);
`ifdef SPI_SEQ_RX_EN
                    if (mon_e.rx_chk) chk("done_rx_data", {16'h0, rx_data_a[k]}, {16'h0, mon_e.rx});
`endif
                end
            end
            if (rst_n && busy_a[k]) begin
                if (!prev_sclk[k] && sclk_a[k]) rises[k]++;
                if (prev_sclk[k] && !sclk_a[k]) begin
                    falls[k]++;
                    chk("fall_index", {28'h0, idx_a[k]},
                        (falls[k] < 16) ? {28'h0, 4'(prev_idx[k] - 4'd1)} : 32'd0);
                end
            end else begin
                rises[k] = 0;
                falls[k] = 0;
            end
            prev_sclk[k] = sclk_a[k];
            prev_idx[k]  = idx_a[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int k, logic [15:0] data, bit push, logic [15:0] rx, bit rx_chk);
        sb_t e;
        int  n = 0;
        tx_data_a[k]  = data;
        tx_valid_a[k] = 1'b1;
        while (!ready_a[k] && n < 3000) begin
            tick();
            n++;
        end
        if (!ready_a[k]) chk("ready_timeout", {31'h0, ready_a[k]}, 32'd1);
        tick();
        tx_valid_a[k] = 1'b0;
        e.data = data;
        e.acc = cyc;
        e.rx = rx;
        e.rx_chk = rx_chk;
        if (push) sbq[k].push_back(e);
        chk("accept_index", {28'h0, idx_a[k]}, 32'd15);
        chk("accept_cs_n", {31'h0, cs_n_a[k]}, 32'd0);
        chk("accept_busy", {31'h0, busy_a[k]}, 32'd1);
        chk("accept_pts_en", {31'h0, pts_en_a[k]}, 32'd1);
        chk("accept_ready", {31'h0, ready_a[k]}, 32'd0);
        chk("accept_sclk", {31'h0, sclk_a[k]}, 32'd0);
        chk("accept_pts_data", {16'h0, pts_data_a[k]}, {16'h0, data});
    endtask

    task automatic wait_done(int k);
        int n = 0;
        while (!done_a[k] && n < 3000) begin
            tick();
            n++;
        end
        chk("done_seen", {31'h0, done_a[k]}, 32'd1);
    endtask

    task automatic check_idle(int k, string tag);
        chk({tag, "_ready"}, {31'h0, ready_a[k]}, 32'd1);
        chk({tag, "_busy"}, {31'h0, busy_a[k]}, 32'd0);
        chk({tag, "_done"}, {31'h0, done_a[k]}, 32'd0);
        chk({tag, "_cs_n"}, {31'h0, cs_n_a[k]}, 32'd1);
        chk({tag, "_sclk"}, {31'h0, sclk_a[k]}, 32'd0);
        chk({tag, "_pts_en"}, {31'h0, pts_en_a[k]}, 32'd0);
    endtask

    task automatic check_reset(int k);
        check_idle(k, "reset");
        chk("reset_index", {28'h0, idx_a[k]}, 32'd0);
        chk("reset_pts_data", {16'h0, pts_data_a[k]}, 32'd0);
`ifdef SPI_SEQ_RX_EN
        chk("reset_rx_data", {16'h0, rx_data_a[k]}, 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        logic ps;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_valid_a[k] = 1'b0;
            tx_data_a[k]  = '0;
            abort_a[k]    = 1'b0;
        end
`ifdef SPI_SEQ_RX_EN
        rx_pat = 16'h0000;
`endif
        repeat (3) tick();
        for (int k = 0; k < 3; k++) check_reset(k);
        rst_n = 1'b1;
        repeat (2) tick();

        // single frame, CLK_DIV=2: 68-cycle latency, index walk 15..0
        send(1, 16'hA5C3, 1'b1, 16'h0, 1'b0);
        wait_done(1);
        tick();
        check_idle(1, "after_frame");

        // back-to-back: second word offered in the done cycle
        send(1, 16'h0001, 1'b1, 16'h0, 1'b0);
        wait_done(1);
        chk("b2b_cs_n_done_cycle", {31'h0, cs_n_a[1]}, 32'd1);
        chk("b2b_ready_done_cycle", {31'h0, ready_a[1]}, 32'd1);
        send(1, 16'hFFFF, 1'b1, 16'h0, 1'b0);
        repeat (30) tick();
        chk("b2b_mid_pts_data", {16'h0, pts_data_a[1]}, 32'h0000FFFF);
        wait_done(1);
        tick();

        // abort after the 5th rising sclk, CLK_DIV=4
        send(2, 16'hA5A5, 1'b0, 16'h0, 1'b0);
        r = 0;
        n = 0;
        ps = sclk_a[2];
        while (r < 5 && n < 1000) begin
            tick();
            if (!ps && sclk_a[2]) r++;
            ps = sclk_a[2];
            n++;
        end
        chk("abort_rises_seen", 32'(r), 32'd5);
        abort_a[2] = 1'b1;
        tick();
        abort_a[2] = 1'b0;
        check_idle(2, "abort");
        repeat (200) tick();

        // abort together with tx_valid in IDLE: accept proceeds
        abort_a[2] = 1'b1;
        send(2, 16'h1234, 1'b1, 16'h0, 1'b0);
        abort_a[2] = 1'b0;
        wait_done(2);
        tick();

        // reset pulse during SHIFT, CLK_DIV=2
        send(1, 16'h5A5A, 1'b0, 16'h0, 1'b0);
        repeat (20) tick();
        chk("pre_reset_busy", {31'h0, busy_a[1]}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset(1);
        rst_n = 1'b1;
        repeat (100) tick();

        // tx_valid held high through a frame is not taken until the done cycle
        send(1, 16'hC001, 1'b1, 16'h0, 1'b0);
        tx_data_a[1]  = 16'hBEEF;
        tx_valid_a[1] = 1'b1;
        wait_done(1);
        send(1, 16'hBEEF, 1'b1, 16'h0, 1'b0);
        wait_done(1);
        tick();

        // CLK_DIV=1 frame (with receive checks when enabled)
`ifdef SPI_SEQ_RX_EN
        rx_pat = 16'h3C5A;
`endif
        send(0, 16'h0F0F, 1'b1, 16'h3C5A, 1'b1);
        wait_done(0);
        tick();
`ifdef SPI_SEQ_RX_EN
        rx_pat = 16'hFFFF;
`endif
        send(0, 16'h8001, 1'b0, 16'h0, 1'b0);
        repeat (10) tick();
        abort_a[0] = 1'b1;
        tick();
        abort_a[0] = 1'b0;
        check_idle(0, "abort_div1");
        repeat (40) tick();
`ifdef SPI_SEQ_RX_EN
        chk("rx_hold_after_abort", {16'h0, rx_data_a[0]}, 32'h00003C5A);
`endif
        send(0, 16'h8001, 1'b1, 16'h3C5A, 1'b0);
        wait_done(0);

        repeat (50) tick();
        for (int k = 0; k < 3; k++) chk("scoreboard_empty", 32'(sbq[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
